// File: rtl/ahb_ram_slave_pkg.sv
// Shared AHB-lite bus types and the bus address map.
// Imported by the RAM responder, its lane decoder and the bench.
package ahb_ram_slave_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } transfer_kind;

  typedef logic [2:0] transfer_size;
  localparam transfer_size HSIZE_8  = 3'd0;
  localparam transfer_size HSIZE_16 = 3'd1;
  localparam transfer_size HSIZE_32 = 3'd2;

  typedef logic [2:0] transfer_burst;
  typedef logic [3:0] transfer_protection;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } transfer_response;

  // Lower byte bound of each slave slot.
  localparam logic [1:0][31:0] AHB_ADDR_MAP = {32'h0000_4000, 32'h0000_0000};

endpackage

// File: rtl/ahb_ram_lanes.sv
// Maps transfer size and low address bits to little-endian write lanes.
// Only used when AHB_RAM_SIZED_EN is defined.
module ahb_ram_lanes
  import ahb_ram_slave_pkg::*;
(
  input  transfer_size size_i,
  input  logic [1:0]   addr_lo_i,
  output logic [3:0]   strb_o,
  output logic         misalign_o
);

  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      HSIZE_8:  strb_o = 4'b0001 << addr_lo_i;
      HSIZE_16: begin
        strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      HSIZE_32: begin
        strb_o     = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-lite responder backed by word-addressed RAM, with wait states and ERROR response.
// Define AHB_RAM_SIZED_EN to support byte and halfword transfers.
module ahb_ram_slave
  import ahb_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               write,
  input  logic [31:0]        addr,
  input  transfer_size       size,
  input  transfer_burst      burst,
  input  transfer_protection prot,
  input  logic               mastlock,
  input  transfer_kind       trans,
  input  logic               ready_in,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready_out,
  output transfer_response   resp
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} ram_slv_state;

  ram_slv_state   state_q, state_d;
  logic           write_q, write_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [3:0]     strb_q, strb_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [31:0]    off;
  logic [AW-1:0]  a_idx, rd_idx;
  logic [3:0]     a_strb;
  logic           a_err, range_err, take, commit, load_rd;
  logic [31:0]    wr_word;
  logic           unused_ign;

  assign unused_ign = ^{burst, prot, mastlock, trans[0]};

  assign off       = addr - BASE;
  assign a_idx     = off[AW+1:2];
  assign range_err = off >= DEPTH_WORDS * 4;

`ifdef AHB_RAM_SIZED_EN
  logic a_mis;
  ahb_ram_lanes u_lanes (
    .size_i     (size),
    .addr_lo_i  (addr[1:0]),
    .strb_o     (a_strb),
    .misalign_o (a_mis)
  );
  assign a_err = range_err | (size > HSIZE_32) | a_mis;
`else
  assign a_strb = 4'b1111;
  assign a_err  = range_err | (size != HSIZE_32) | (addr[1:0] != 2'b00);
`endif

  // A new address phase is only taken once any previous data phase is on its last cycle.
  assign take = sel && ready_in && trans[1] &&
                (state_q == StIdle || state_q == StDone || state_q == StErr2);

  always_comb begin
    wr_word = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (strb_q[b]) wr_word[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    idx_d     = idx_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rd_idx    = idx_q;
    commit    = 1'b0;
    load_rd   = 1'b0;
    ready_out = 1'b1;
    resp      = RespOkay;

    case (state_q)
      StWait: begin
        ready_out = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          load_rd = !write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        commit  = write_q;
        state_d = StIdle;
      end
      StErr1: begin
        ready_out = 1'b0;
        resp      = RespError;
        state_d   = StErr2;
      end
      StErr2: begin
        resp    = RespError;
        state_d = StIdle;
      end
      default: ;
    endcase

    if (take) begin
      write_d = write;
      idx_d   = a_idx;
      strb_d  = a_strb;
      if (a_err) begin
        state_d = StErr1;
      end else if (WAIT_STATES == 0) begin
        state_d = StDone;
        rd_idx  = a_idx;
        load_rd = !write;
      end else begin
        state_d = StWait;
        cnt_d   = WaitInit;
      end
    end

    // Forward a same-edge write so read-after-write sees the merged word.
    if (load_rd) begin
      rdata_d = (commit && idx_q == rd_idx) ? wr_word : mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      idx_q   <= '0;
      strb_q  <= 4'b0000;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit) mem_q[idx_q] <= wr_word;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: two slaves (0 and 3 wait states) on one bus, pipelined driver,
// directed table, reset-mid-wait sequence and randomized traffic against a memory model.
module tb_ahb_ram_slave;
  import ahb_ram_slave_pkg::*;

  localparam int unsigned Depth = 16;
  localparam logic [31:0] Base0 = AHB_ADDR_MAP[0];
  localparam logic [31:0] Base3 = AHB_ADDR_MAP[1];
`ifdef AHB_RAM_SIZED_EN
  localparam bit Sized = 1'b1;
`else
  localparam bit Sized = 1'b0;
`endif

  typedef struct packed {
    bit           dev;
    bit           write;
    transfer_kind kind;
    bit           sel;
    logic [31:0]  addr;
    logic [2:0]   size;
    logic [31:0]  wdata;
    bit           exp_err;
    bit           chk_rd;
    logic [31:0]  exp_rd;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel0 = 1'b0, sel3 = 1'b0, write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  transfer_size size = HSIZE_32;
  transfer_kind trans = TransIdle;
  logic [31:0] rdata0, rdata3;
  logic rdy0, rdy3, ready_in;
  transfer_response resp0, resp3;

  assign ready_in = rdy0 & rdy3;

  always #5 clk = ~clk;

  ahb_ram_slave #(.BASE(Base0), .DEPTH_WORDS(Depth), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel0), .write(write), .addr(addr), .size(size),
    .burst(3'b000), .prot(4'b0011), .mastlock(1'b0), .trans(trans), .ready_in(ready_in),
    .wdata(wdata), .rdata(rdata0), .ready_out(rdy0), .resp(resp0)
  );

  ahb_ram_slave #(.BASE(Base3), .DEPTH_WORDS(Depth), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .sel(sel3), .write(write), .addr(addr), .size(size),
    .burst(3'b001), .prot(4'b0001), .mastlock(1'b0), .trans(trans), .ready_in(ready_in),
    .wdata(wdata), .rdata(rdata3), .ready_out(rdy3), .resp(resp3)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] mem [2][Depth];
  op_t ops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Sequential reference: an op is legal iff its size is supported, it is naturally
  // aligned and its offset lies inside the RAM; legal writes update the chosen bytes.
  function automatic op_t model_op(op_t o);
    logic [31:0] off;
    int unsigned nb, w, lo;
    off = o.addr - (o.dev ? Base3 : Base0);
    nb  = 1 << o.size;
    lo  = o.addr % 4;
    o.exp_err = !((o.size == 3'd2 || (Sized && o.size < 3'd2)) && off < Depth * 4 &&
                  (o.addr % nb) == 0);
    o.chk_rd  = !o.exp_err && !o.write;
    o.exp_rd  = '0;
    if (!o.exp_err) begin
      w = off / 4;
      if (o.write) begin
        for (int b = lo; b < lo + nb; b++) mem[o.dev][w][8*b +: 8] = o.wdata[8*b +: 8];
      end else begin
        o.exp_rd = mem[o.dev][w];
      end
    end
    return o;
  endfunction

  function automatic op_t mk(bit dev, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd,
                             bit err, bit crd, logic [31:0] erd);
    op_t o;
    o.dev = dev; o.write = wr; o.kind = TransNonseq; o.sel = 1'b1; o.addr = a; o.size = sz;
    o.wdata = wd; o.exp_err = err; o.chk_rd = crd; o.exp_rd = erd;
    return o;
  endfunction

  // Pipelined master: address of op N+1 overlaps the last data cycle of op N.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_ops();
    int ai = 0, di = -1, low = 0, dcyc = 0, cyc = 0;
    transfer_response first = RespOkay, r;
    int unsigned exp_low;
    while ((ai < ops.size() || di >= 0) && cyc < 20000) begin
      if (ai < ops.size()) begin
        sel0  = ops[ai].sel && !ops[ai].dev;
        sel3  = ops[ai].sel && ops[ai].dev;
        trans = ops[ai].kind;
        write = ops[ai].write;
        addr  = ops[ai].addr;
        size  = ops[ai].size;
      end else begin
        sel0 = 1'b0; sel3 = 1'b0; trans = TransIdle;
      end
      wdata = (di >= 0) ? ops[di].wdata : 32'h0;
      @(negedge clk);
      if (di >= 0) begin
        r = ops[di].dev ? resp3 : resp0;
        if (dcyc == 0) first = r;
        dcyc++;
        if (!ready_in) low++;
      end
      if (ready_in) begin
        if (di >= 0) begin
          exp_low = ops[di].exp_err ? 1 : (ops[di].dev ? 3 : 0);
          chk($sformatf("op%0d wait cycles", di), 32'(low), exp_low);
          chk($sformatf("op%0d resp", di), 32'(r), ops[di].exp_err ? 32'd1 : 32'd0);
          if (ops[di].exp_err) chk($sformatf("op%0d first resp", di), 32'(first), 32'd1);
          if (ops[di].chk_rd)
            chk($sformatf("op%0d rdata", di), ops[di].dev ? rdata3 : rdata0, ops[di].exp_rd);
        end
        di = -1;
        if (ai < ops.size()) begin
          if (ops[ai].kind[1]) begin
            di = ai; low = 0; dcyc = 0;
          end
          ai++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++;
      $display("FAIL run_ops timeout: stuck at op %0d, expected completion", ai);
    end
    sel0 = 1'b0; sel3 = 1'b0; trans = TransIdle;
    ops.delete();
  endtask

  initial begin
    op_t tbl[12];
    op_t o, m;
    logic [31:0] off;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready0", 32'(rdy0), 32'd1);
    chk("reset resp0", 32'(resp0), 32'd0);
    chk("reset rdata0", rdata0, 32'h0);
    chk("reset ready3", 32'(rdy3), 32'd1);
    chk("reset resp3", 32'(resp3), 32'd0);
    chk("reset rdata3", rdata3, 32'h0);
    @(posedge clk); #1;

    // Give every word a known value so later reads have a defined expectation.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < Depth; w++) begin
        o = mk(d[0], 1'b1, (d == 1 ? Base3 : Base0) + 32'(4 * w), 3'd2, $urandom, 1'b0, 1'b0, 0);
        ops.push_back(model_op(o));
      end
    end

    tbl[0]  = mk(0, 1, Base0 + 8,         3'd2, 32'hDEADBEEF, 0, 0, 0);
    tbl[1]  = mk(0, 0, Base0 + 8,         3'd2, 32'h0,        0, 1, 32'hDEADBEEF);
    tbl[2]  = mk(0, 1, Base0,             3'd2, 32'h11223344, 0, 0, 0);
    tbl[3]  = mk(0, 1, Base0 + Depth * 4, 3'd2, 32'hCAFEF00D, 1, 0, 0);
    tbl[4]  = mk(0, 0, Base0,             3'd2, 32'h0,        0, 1, 32'h11223344);
    tbl[5]  = mk(0, 1, Base0 + 2,         3'd0, 32'h00AA0000, !Sized, 0, 0);
    tbl[6]  = mk(0, 0, Base0,             3'd2, 32'h0,        0, 1,
                 Sized ? 32'h11AA3344 : 32'h11223344);
    tbl[7]  = mk(0, 1, Base0 + 1,         3'd1, 32'h5555AAAA, 1, 0, 0);
    tbl[8]  = mk(0, 0, Base0,             3'd2, 32'h0,        0, 1,
                 Sized ? 32'h11AA3344 : 32'h11223344);
    tbl[9]  = mk(1, 1, Base3 + 4,         3'd2, 32'h0BADCAFE, 0, 0, 0);
    tbl[10] = mk(1, 0, Base3 + 4,         3'd2, 32'h0,        0, 1, 32'h0BADCAFE);
    tbl[11] = mk(1, 1, Base3 + 12,        3'd2, 32'h5A5A5A5A, 0, 0, 0);
    foreach (tbl[i]) begin
      m = model_op(tbl[i]);
      ops.push_back(tbl[i]);
    end
    run_ops();

    // Reset one cycle into the wait phase of a write: the write must be dropped.
    sel3 = 1'b1; trans = TransNonseq; write = 1'b1; addr = Base3 + 12; size = HSIZE_32;
    @(posedge clk); #1;
    sel3 = 1'b0; trans = TransIdle; wdata = 32'h12345678;
    @(negedge clk);
    chk("rst-wait ready low", 32'(rdy3), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst-wait ready", 32'(rdy3), 32'd1);
    chk("rst-wait resp", 32'(resp3), 32'd0);
    chk("rst-wait rdata", rdata3, 32'h0);
    @(posedge clk); #1;
    ops.push_back(mk(1, 0, Base3 + 12, 3'd2, 32'h0, 0, 1, 32'h5A5A5A5A));
    run_ops();

    for (int i = 0; i < 300; i++) begin
      o.dev   = $urandom_range(0, 1) == 1;
      o.write = $urandom_range(0, 1) == 1;
      o.kind  = ($urandom_range(0, 5) == 0) ? transfer_kind'(2'($urandom_range(0, 1)))
                                            : transfer_kind'(2'($urandom_range(2, 3)));
      o.sel   = o.kind[1] ? 1'b1 : ($urandom_range(0, 1) == 1);
      o.size  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      off     = $urandom_range(0, Depth * 4 - 1);
      if ($urandom_range(0, 3) != 0) off = off & ~((32'd1 << o.size) - 1);
      if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 1) ? off + Depth * 4 : 32'hFFFF_FFFC;
      o.addr  = (o.dev ? Base3 : Base0) + off;
      o.wdata = $urandom;
      o.exp_err = 1'b0; o.chk_rd = 1'b0; o.exp_rd = '0;
      if (o.kind[1]) o = model_op(o);
      ops.push_back(o);
    end
    run_ops();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
